// File: rtl/instr_cache_pkg.sv
// icache_pkg: shared types and address helpers for the instruction cache.
// Holds the FSM state enum, default field widths and tag/index extraction.
package icache_pkg;

  localparam int TAG_W = 28;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    DONE = 2'd2
  } icache_state_e;

  // Tag is everything above the index and the byte offset.
  function automatic logic [31:0] addr_tag(
    input logic [31:0] a,
    input int          iw
  );
    return a >> (iw + 2);
  endfunction

  function automatic logic [31:0] addr_idx(
    input logic [31:0] a,
    input int          iw
  );
    return (a >> 2) & ((32'd1 << iw) - 32'd1);
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Fetch-side and memory-side bundles for instr_cache.
// cpu: master = fetch stage, slave = cache; mem: master = cache, slave = imem.
interface icache_cpu_if #(parameter int XLEN = 32);
  logic            cpu_req;
  logic [XLEN-1:0] cpu_addr;
  logic [XLEN-1:0] cpu_instr;
  logic            cpu_valid;
  logic            stall;
  logic            flush;

  modport master (
    output cpu_req, cpu_addr, flush,
    input  cpu_instr, cpu_valid, stall
  );
  modport slave (
    input  cpu_req, cpu_addr, flush,
    output cpu_instr, cpu_valid, stall
  );
endinterface

interface icache_mem_if #(parameter int XLEN = 32);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_ready, mem_rdata
  );
  modport slave (
    input  mem_req, mem_addr,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/instr_cache_tag_array.sv
// icache_tag_array: valid/tag/data storage, async read, one write port.
// Ports: rd_idx -> rd_valid/rd_tag/rd_data; we/wr_*; clear_valid wipes valids.
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int N_LINES = 4,
  parameter int IW      = IDX_W,
  parameter int TW      = TAG_W,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [DW-1:0] rd_data,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  logic [DW-1:0] wr_data,
  input  logic          clear_valid
);

  logic [N_LINES-1:0] valid;
  logic [TW-1:0]      tags [N_LINES];
  logic [DW-1:0]      data [N_LINES];

  // A clear on the fill edge wins: the word lands but stays invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (clear_valid) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, one-word-per-line I-cache (IDLE/MISS/DONE).
// Ports: clk, reset (async low), cpu (slave), mem (master);
// hit_count/miss_count only when ICACHE_STATS_EN is defined.
module instr_cache
  import icache_pkg::*;
#(
  parameter int N_LINES = 4,
  parameter int XLEN    = 32
) (
  input  logic         clk,
  input  logic         reset,
  icache_cpu_if.slave  cpu,
  icache_mem_if.master mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IW = $clog2(N_LINES);
  localparam int TW = XLEN - IW - 2;

  icache_state_e   state;
  logic [XLEN-1:0] fill_data;

  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   req_tag;
  logic [IW-1:0]   fill_idx;
  logic [TW-1:0]   fill_tag;
  logic            line_valid;
  logic [TW-1:0]   line_tag;
  logic [XLEN-1:0] line_data;
  logic            fill_we;
  logic            hit;
  logic            miss;

  assign req_idx  = IW'(addr_idx(cpu.cpu_addr, IW));
  assign req_tag  = TW'(addr_tag(cpu.cpu_addr, IW));
  // mem_addr doubles as the latched miss address.
  assign fill_idx = IW'(addr_idx(mem.mem_addr, IW));
  assign fill_tag = TW'(addr_tag(mem.mem_addr, IW));
  assign fill_we  = (state == MISS) & mem.mem_ready;

  icache_tag_array #(
    .N_LINES (N_LINES),
    .IW      (IW),
    .TW      (TW),
    .DW      (XLEN)
  ) u_tags (
    .clk         (clk),
    .reset       (reset),
    .rd_idx      (req_idx),
    .rd_valid    (line_valid),
    .rd_tag      (line_tag),
    .rd_data     (line_data),
    .we          (fill_we),
    .wr_idx      (fill_idx),
    .wr_tag      (fill_tag),
    .wr_data     (mem.mem_rdata),
    .clear_valid (cpu.flush)
  );

  // Flush masks a hit so the request refetches after the wipe.
  assign hit  = (state == IDLE) & cpu.cpu_req & line_valid
              & (line_tag == req_tag) & ~cpu.flush;
  assign miss = (state == IDLE) & cpu.cpu_req & ~hit;

  always_comb begin
    cpu.cpu_valid = 1'b0;
    cpu.cpu_instr = '0;
    cpu.stall     = 1'b0;
    unique case (state)
      IDLE: begin
        cpu.cpu_valid = hit;
        cpu.cpu_instr = hit ? line_data : '0;
        cpu.stall     = miss;
      end
      MISS: cpu.stall = 1'b1;
      DONE: begin
        cpu.cpu_valid = 1'b1;
        cpu.cpu_instr = fill_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      fill_data    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss) begin
            state        <= MISS;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= cpu.cpu_addr & ~XLEN'(3);
          end
        end
        MISS: begin
          if (mem.mem_ready) begin
            state       <= DONE;
            mem.mem_req <= 1'b0;
            fill_data   <= mem.mem_rdata;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != '1) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss && miss_count != '1) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed + random fetches against a line-level model.
// Memory is a bench array; flush/reset/latency are driven per step.
module tb_instr_cache;

  logic clk;
  logic reset;

  icache_cpu_if #(.XLEN(32)) cpu_if ();
  icache_mem_if #(.XLEN(32)) mem_if ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  instr_cache #(
    .N_LINES (4),
    .XLEN    (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cpu   (cpu_if),
    .mem   (mem_if)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_hit    = 0;
  int n_miss   = 0;

  logic [31:0] mem [64];
  bit          mv  [4];
  logic [31:0] mt  [4];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
  endtask

  // fk: cycle the flush pulse lands in (0 = request cycle,
  // 1..lat = miss cycles, -1 = none).
  task automatic fetch(input logic [31:0] a, input int lat,
                       input int fk);
    int          idx = int'((a >> 2) % 4);
    logic [31:0] w   = mem[(a >> 2) % 64];
    bit          hit;
    int          st;
    @(negedge clk);
    cpu_if.cpu_req  = 1'b1;
    cpu_if.cpu_addr = a;
    cpu_if.flush    = (fk == 0);
    hit = mv[idx] && (mt[idx] == a / 16) && (fk != 0);
    #1;
    if (hit) begin
      chk("hit_valid", 32'(cpu_if.cpu_valid), 32'd1);
      chk("hit_instr", cpu_if.cpu_instr, w);
      chk("hit_stall", 32'(cpu_if.stall), 32'd0);
      n_hit++;
      @(negedge clk);
      cpu_if.cpu_req = 1'b0;
      return;
    end
    n_miss++;
    chk("miss_stall", 32'(cpu_if.stall), 32'd1);
    chk("miss_valid", 32'(cpu_if.cpu_valid), 32'd0);
    if (fk == 0) model_clear();
    st = 1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      cpu_if.cpu_addr  = $urandom;
      cpu_if.flush     = (fk == k);
      mem_if.mem_ready = (k == lat);
      mem_if.mem_rdata = (k == lat) ? w : $urandom;
      #1;
      chk("mem_req", 32'(mem_if.mem_req), 32'd1);
      chk("mem_addr", mem_if.mem_addr, a & ~32'd3);
      if (cpu_if.stall) st++;
      if (fk == k) model_clear();
    end
    @(negedge clk);
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = $urandom;
    cpu_if.flush     = 1'b0;
    cpu_if.cpu_req   = 1'b0;
    #1;
    chk("done_valid", 32'(cpu_if.cpu_valid), 32'd1);
    chk("done_instr", cpu_if.cpu_instr, w);
    chk("done_stall", 32'(cpu_if.stall), 32'd0);
    chk("stall_cycles", st, 1 + lat);
    chk("done_mem_req", 32'(mem_if.mem_req), 32'd0);
    mv[idx] = (fk != lat);
    mt[idx] = a / 16;
  endtask

  // Idle cycle with stray mem_ready and optional flush pulse.
  task automatic idle(input bit fl);
    @(negedge clk);
    cpu_if.cpu_req   = 1'b0;
    cpu_if.flush     = fl;
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = $urandom;
    #1;
    chk("idle_valid", 32'(cpu_if.cpu_valid), 32'd0);
    chk("idle_stall", 32'(cpu_if.stall), 32'd0);
    chk("idle_mem_req", 32'(mem_if.mem_req), 32'd0);
    @(negedge clk);
    cpu_if.flush     = 1'b0;
    mem_if.mem_ready = 1'b0;
    if (fl) model_clear();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[16] = 32'h2008_0007;
    model_clear();
    cpu_if.cpu_req   = 1'b0;
    cpu_if.cpu_addr  = '0;
    cpu_if.flush     = 1'b0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
    chk("rst_stall", 32'(cpu_if.stall), 32'd0);
    chk("rst_valid", 32'(cpu_if.cpu_valid), 32'd0);
    chk("rst_instr", cpu_if.cpu_instr, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    fetch(32'h40, 3, -1);
    fetch(32'h40, 1, -1);
    idle(1'b0);

    fetch(32'h00, 2, -1);
    fetch(32'h10, 1, -1);
    fetch(32'h00, 2, -1);

    fetch(32'h24, 1, -1);

    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 1, -1);
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 1, -1);
    idle(1'b1);
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 2, -1);

    fetch(32'h38, 2, 2);
    fetch(32'h38, 1, -1);
    fetch(32'h38, 1, -1);
    fetch(32'h38, 1, 0);

    // Reset in the middle of a miss.
    fetch(32'h40, 2, -1);
    @(negedge clk);
    cpu_if.cpu_req  = 1'b1;
    cpu_if.cpu_addr = 32'h80;
    @(negedge clk);
    #1;
    chk("rmid_mem_req", 32'(mem_if.mem_req), 32'd1);
    chk("rmid_stall", 32'(cpu_if.stall), 32'd1);
    cpu_if.cpu_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("rmid_req_drop", 32'(mem_if.mem_req), 32'd0);
    chk("rmid_stall_drop", 32'(cpu_if.stall), 32'd0);
    chk("rmid_valid_drop", 32'(cpu_if.cpu_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    n_hit  = 0;
    n_miss = 0;
    fetch(32'h40, 2, -1);

    for (int i = 0; i < 60; i++) begin
      automatic int lat = int'($urandom_range(1, 4));
      automatic int fk  = ($urandom_range(0, 5) == 0)
                        ? int'($urandom_range(0, lat)) : -1;
      fetch(32'($urandom_range(0, 63)) << 2, lat, fk);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(0, 3) == 0);
    end

`ifdef ICACHE_STATS_EN
    #1;
    chk("hit_count", hit_count, 32'(n_hit));
    chk("miss_count", miss_count, 32'(n_miss));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
